// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared constants for the decode hazard controller: ISA opcode/aluop codes and
// the hazard FSM state encoding.
package decode_hazard_ctrl_pkg;

  localparam int unsigned OP_W  = 5;
  localparam int unsigned REG_W = 5;

  localparam logic [OP_W-1:0] OP_LW   = 5'b01000;
  localparam logic [OP_W-1:0] OP_SW   = 5'b00111;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OP_W-1:0] OP_BNE  = 5'b00010;
  localparam logic [OP_W-1:0] OP_BLT  = 5'b00110;
  localparam logic [OP_W-1:0] OP_JR   = 5'b00100;
  localparam logic [OP_W-1:0] OP_BEX  = 5'b10110;

  localparam logic [OP_W-1:0] ALU_MUL = 5'b00110;
  localparam logic [OP_W-1:0] ALU_DIV = 5'b00111;

  localparam logic [REG_W-1:0] REG_STATUS = 5'd30;

  typedef enum logic {
    HZ_RUN     = 1'b0,
    HZ_MD_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: decode/execute fields in,
// latch enables and bubble/flush strobes out.
interface decode_hazard_ctrl_if;
  import decode_hazard_ctrl_pkg::*;

  logic [OP_W-1:0]  opcode_d;
  logic [REG_W-1:0] rd_d;
  logic [REG_W-1:0] rs_d;
  logic [REG_W-1:0] rt_d;
  logic             R_d;
  logic [OP_W-1:0]  opcode_x;
  logic [REG_W-1:0] rd_x;
  logic [OP_W-1:0]  aluop_x;
  logic             R_x;
  logic             branch_taken_x;
  logic             md_ready;

  logic pc_en;
  logic fd_en;
  logic dx_en;
  logic fd_flush;
  logic dx_bubble;
  logic xm_bubble;
  logic md_busy;
  logic md_timeout;

  modport master (
    output opcode_d, rd_d, rs_d, rt_d, R_d,
    output opcode_x, rd_x, aluop_x, R_x, branch_taken_x, md_ready,
    input  pc_en, fd_en, dx_en, fd_flush, dx_bubble, xm_bubble, md_busy, md_timeout
  );

  modport slave (
    input  opcode_d, rd_d, rs_d, rt_d, R_d,
    input  opcode_x, rd_x, aluop_x, R_x, branch_taken_x, md_ready,
    output pc_en, fd_en, dx_en, fd_flush, dx_bubble, xm_bubble, md_busy, md_timeout
  );
endinterface

// File: rtl/decode_hazard_ctrl_src_reg_match.sv
// Combinational check: does the instruction in decode read register reg_num?
// Register 0 never matches.
module decode_hazard_ctrl_src_reg_match
  import decode_hazard_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]  opcode_d,
  input  logic             R_d,
  input  logic [REG_W-1:0] rd_d,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic [REG_W-1:0] reg_num,
  output logic             is_src_c
);

  logic hit;

  always_comb begin
    hit = 1'b0;
    if (R_d) begin
      hit = (rs_d == reg_num) || (rt_d == reg_num);
    end else begin
      unique case (opcode_d)
        OP_ADDI, OP_LW:        hit = (rs_d == reg_num);
        OP_SW, OP_BNE, OP_BLT: hit = (rd_d == reg_num) || (rs_d == reg_num);
        OP_JR:                 hit = (rd_d == reg_num);
        OP_BEX:                hit = (REG_STATUS == reg_num);
        default:               hit = 1'b0;
      endcase
    end
    is_src_c = hit && (reg_num != '0);
  end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode/execute pipeline control: load-use stall, taken-branch flush and
// multi-cycle mul/div occupancy with a timeout.
module decode_hazard_ctrl
  import decode_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 32,
  parameter int unsigned MD_CNT_W   = 6
) (
  input  logic                 clk,
  input  logic                 clr,
  decode_hazard_ctrl_if.slave  bus
);

  hz_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic                timeout_q, timeout_d;

  logic rd_x_is_src;
  logic load_use;
  logic md_issue;

  decode_hazard_ctrl_src_reg_match u_src_match (
    .opcode_d (bus.opcode_d),
    .R_d      (bus.R_d),
    .rd_d     (bus.rd_d),
    .rs_d     (bus.rs_d),
    .rt_d     (bus.rt_d),
    .reg_num  (bus.rd_x),
    .is_src_c (rd_x_is_src)
  );

  assign load_use = (bus.opcode_x == OP_LW) && rd_x_is_src;
  assign md_issue = bus.R_x && ((bus.aluop_x == ALU_MUL) || (bus.aluop_x == ALU_DIV))
                    && (state_q == HZ_RUN);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= HZ_RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    timeout_d     = 1'b0;
    bus.pc_en     = 1'b1;
    bus.fd_en     = 1'b1;
    bus.dx_en     = 1'b1;
    bus.fd_flush  = 1'b0;
    bus.dx_bubble = 1'b0;
    bus.xm_bubble = 1'b0;
    bus.md_busy   = 1'b0;

    unique case (state_q)
      HZ_RUN: begin
        if (md_issue) begin
          state_d       = HZ_MD_WAIT;
          cnt_d         = MD_CNT_W'(1);
          bus.pc_en     = 1'b0;
          bus.fd_en     = 1'b0;
          bus.dx_en     = 1'b0;
          bus.xm_bubble = 1'b1;
        end else if (bus.branch_taken_x) begin
          bus.fd_flush  = 1'b1;
          bus.dx_bubble = 1'b1;
        end else if (load_use) begin
          bus.pc_en     = 1'b0;
          bus.fd_en     = 1'b0;
          bus.dx_bubble = 1'b1;
        end
      end
      HZ_MD_WAIT: begin
        bus.pc_en     = 1'b0;
        bus.fd_en     = 1'b0;
        bus.dx_en     = 1'b0;
        bus.md_busy   = 1'b1;
        bus.xm_bubble = 1'b1;
        // Release the X/M bubble on the exit cycle so the result (or garbage on timeout) advances.
        if (bus.md_ready) begin
          state_d       = HZ_RUN;
          cnt_d         = '0;
          bus.xm_bubble = 1'b0;
        end else if (cnt_q == MD_CNT_W'(MD_LATENCY - 1)) begin
          state_d       = HZ_RUN;
          cnt_d         = '0;
          timeout_d     = 1'b1;
          bus.xm_bubble = 1'b0;
        end else begin
          cnt_d = cnt_q + MD_CNT_W'(1);
        end
      end
      default: state_d = HZ_RUN;
    endcase
  end

  assign bus.md_timeout = timeout_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed scenarios followed by random traffic, checked cycle by cycle against
// a behavioural model of the stall/flush/mul-div rules.
module tb_decode_hazard_ctrl;

  localparam int unsigned LAT = 32;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  decode_hazard_ctrl_if bus();

  decode_hazard_ctrl #(.MD_LATENCY(LAT), .MD_CNT_W(6)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: whether a mul/div holds execute, wait cycles spent so far, pending timeout pulse.
  bit m_md      = 1'b0;
  int m_elapsed = 0;
  bit m_to      = 1'b0;

  function automatic bit reads_reg(input logic [4:0] op, input logic r,
                                   input logic [4:0] rd, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic [4:0] rn);
    logic [4:0] srcs[$];
    bit found = 1'b0;
    if (r) srcs = '{rs, rt};
    else if (op == 5'b01000 || op == 5'b00101) srcs = '{rs};
    else if (op == 5'b00111 || op == 5'b00010 || op == 5'b00110) srcs = '{rd, rs};
    else if (op == 5'b00100) srcs = '{rd};
    else if (op == 5'b10110) srcs = '{5'd30};
    foreach (srcs[i]) if (srcs[i] == rn) found = 1'b1;
    return found && (rn != 5'd0);
  endfunction

  task automatic set_d(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic r);
    bus.opcode_d = op; bus.rd_d = rd; bus.rs_d = rs; bus.rt_d = rt; bus.R_d = r;
  endtask

  task automatic set_x(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] aluop,
                       input logic r);
    bus.opcode_x = op; bus.rd_x = rd; bus.aluop_x = aluop; bus.R_x = r;
  endtask

  // Check outputs mid-cycle against the model, then advance model and clock.
  task automatic tick(input string tag);
    logic [7:0] exp_v, obs_v;
    bit pc, fd, dx, ff, db, xb, busy;
    bit n_md, n_to, lu, iss;
    int n_el;
    @(negedge clk);
    pc = 1; fd = 1; dx = 1; ff = 0; db = 0; xb = 0; busy = 0;
    n_md = m_md; n_to = 0; n_el = m_elapsed;
    lu  = (bus.opcode_x == 5'b01000) &&
          reads_reg(bus.opcode_d, bus.R_d, bus.rd_d, bus.rs_d, bus.rt_d, bus.rd_x);
    iss = bus.R_x && (bus.aluop_x == 5'b00110 || bus.aluop_x == 5'b00111);
    if (m_md) begin
      pc = 0; fd = 0; dx = 0; busy = 1;
      if (bus.md_ready) n_md = 0;
      else if (m_elapsed == LAT - 1) begin n_md = 0; n_to = 1; end
      else begin xb = 1; n_el = m_elapsed + 1; end
    end else if (iss) begin
      pc = 0; fd = 0; dx = 0; xb = 1; n_md = 1; n_el = 1;
    end else if (bus.branch_taken_x) begin
      ff = 1; db = 1;
    end else if (lu) begin
      pc = 0; fd = 0; db = 1;
    end
    exp_v = {pc, fd, dx, ff, db, xb, busy, m_to};
    obs_v = {bus.pc_en, bus.fd_en, bus.dx_en, bus.fd_flush, bus.dx_bubble,
             bus.xm_bubble, bus.md_busy, bus.md_timeout};
    if (!clr) begin
      n_cmp++;
      assert (obs_v === exp_v) else begin
        n_bad++;
        $error("FAIL %s t=%0t observed={pc,fd,dx,ffl,dxb,xmb,busy,to}=%b expected=%b",
               tag, $time, obs_v, exp_v);
      end
      m_md = n_md; m_elapsed = n_el; m_to = n_to;
    end else begin
      m_md = 0; m_elapsed = 0; m_to = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_x();
    set_x(5'b00000, 5'd0, 5'b00000, 1'b0);
    bus.branch_taken_x = 1'b0;
    bus.md_ready = 1'b0;
  endtask

  initial begin
    logic [4:0] ops[8];
    ops = '{5'b01000, 5'b00111, 5'b00101, 5'b00010, 5'b00110, 5'b00100, 5'b10110, 5'b00000};

    clr = 1'b1;
    idle_x();
    set_d(5'b00000, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    tick("reset_state");

    // lw r5 in X, add r6,r5,r2 in D: one-cycle stall
    set_x(5'b01000, 5'd5, 5'b00000, 1'b0);
    set_d(5'b00000, 5'd6, 5'd5, 5'd2, 1'b1);
    tick("load_use_stall");
    idle_x();
    tick("load_use_release");

    // lw r0 never stalls
    set_x(5'b01000, 5'd0, 5'b00000, 1'b0);
    set_d(5'b00000, 5'd6, 5'd0, 5'd1, 1'b1);
    tick("load_r0_no_stall");

    // BEX reads r30 implicitly
    set_x(5'b01000, 5'd30, 5'b00000, 1'b0);
    set_d(5'b10110, 5'd0, 5'd0, 5'd0, 1'b0);
    tick("bex_r30_stall");

    // branch beats load-use
    set_x(5'b01000, 5'd5, 5'b00000, 1'b0);
    set_d(5'b00000, 5'd6, 5'd5, 5'd2, 1'b1);
    bus.branch_taken_x = 1'b1;
    tick("branch_over_load_use");
    idle_x();

    // mul, md_ready 10 cycles after entry
    set_x(5'b00000, 5'd7, 5'b00110, 1'b1);
    tick("mul_issue");
    for (int i = 0; i < 10; i++) tick("mul_wait");
    bus.md_ready = 1'b1;
    tick("mul_ready");
    idle_x();
    tick("mul_resume");

    // div without md_ready runs to timeout
    set_x(5'b00000, 5'd8, 5'b00111, 1'b1);
    tick("div_issue");
    for (int i = 0; i < LAT - 1; i++) tick("div_wait");
    idle_x();
    tick("div_timeout_pulse");
    tick("div_timeout_clear");

    // clr in cycle 5 of MD_WAIT, then counter must restart on the next issue
    set_x(5'b00000, 5'd9, 5'b00110, 1'b1);
    tick("mul2_issue");
    for (int i = 0; i < 4; i++) tick("mul2_wait");
    clr = 1'b1;
    tick("mul2_clr");
    clr = 1'b0;
    idle_x();
    tick("after_clr");
    set_x(5'b00000, 5'd9, 5'b00111, 1'b1);
    tick("reissue");
    for (int i = 0; i < LAT - 1; i++) tick("reissue_wait");
    idle_x();
    tick("reissue_timeout_pulse");

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      set_d(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      set_x(($urandom_range(0, 1) == 0) ? 5'b01000 : ops[$urandom_range(0, 7)],
            5'($urandom_range(0, 7)),
            ($urandom_range(0, 15) == 0) ? (($urandom_range(0, 1) == 0) ? 5'b00110 : 5'b00111)
                                         : 5'($urandom_range(0, 5)),
            1'($urandom_range(0, 1)));
      bus.branch_taken_x = ($urandom_range(0, 7) == 0);
      bus.md_ready       = ($urandom_range(0, 9) == 0);
      clr                = ($urandom_range(0, 99) == 0);
      tick("random");
    end
    clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
